// File: rtl/img_row_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : img_row_buffer
//  Purpose  : Frame store for the im2col stage. Captures an IMG_H x IMG_W
//             pixel frame from a row-major stream and serves a KH-row,
//             full-width window selected by i_addr. The frame is released for
//             refill when the window at the last valid address is consumed.
//  Ports    : i_clk, i_rstn      - clock, synchronous active-low reset
//             i_pix_valid/o_pix_ready/i_pix_data - upstream pixel stream
//             o_post_valid/i_post_ready          - window handshake to im2col
//             i_addr             - window top row
//             o_data[i][j]       - pixel(i_addr+i, j), 0 beyond the last row
//  Options  : IMG_BUF_PINGPONG_EN - two banks so filling the next frame
//             overlaps reading the current one.
//  Revision : 1.0 - initial release
// ============================================================================
module img_row_buffer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int DW    = 8,
  parameter int KH    = 3
) (
  input  logic                               i_clk,
  input  logic                               i_rstn,
  input  logic                               i_pix_valid,
  output logic                               o_pix_ready,
  input  logic [DW-1:0]                      i_pix_data,
  output logic                               o_post_valid,
  input  logic                               i_post_ready,
  input  logic [4:0]                         i_addr,
  output logic [KH-1:0][IMG_W-1:0][DW-1:0]   o_data
);

  localparam int              c_RW        = $clog2(IMG_H);
  localparam int              c_CW        = $clog2(IMG_W);
  localparam logic [c_RW-1:0] c_ROW_MAX   = c_RW'(IMG_H - 1);
  localparam logic [c_CW-1:0] c_COL_MAX   = c_CW'(IMG_W - 1);
  localparam logic [4:0]      c_LAST_ADDR = 5'(IMG_H - KH);
  localparam logic [5:0]      c_IMG_H6    = 6'(IMG_H);

  logic [c_RW-1:0] r_row;
  logic [c_CW-1:0] r_col;
  logic            w_pix_fire;
  logic            w_rd_fire;
  logic            w_last_pix;
  logic            w_release;

  assign w_pix_fire = i_pix_valid & o_pix_ready;
  assign w_rd_fire  = o_post_valid & i_post_ready;
  assign w_last_pix = (r_row == c_ROW_MAX) && (r_col == c_COL_MAX);
  assign w_release  = w_rd_fire && (i_addr == c_LAST_ADDR);

  // Write position; wraps to 0,0 after the last pixel of a frame.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_pix_fire) begin
      if (r_col == c_COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == c_ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

`ifdef IMG_BUF_PINGPONG_EN
  logic [1:0][IMG_H-1:0][IMG_W-1:0][DW-1:0] r_mem;
  logic [1:0] r_full;
  logic       r_wb;
  logic       r_rb;

  assign o_pix_ready  = !r_full[r_wb];
  assign o_post_valid = r_full[r_rb];

  // A completion and a release in the same cycle always hit different banks
  // (completion needs bank wb empty, release needs bank rb full).
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_full <= '0;
      r_wb   <= 1'b0;
      r_rb   <= 1'b0;
    end else begin
      if (w_pix_fire && w_last_pix) begin
        r_full[r_wb] <= 1'b1;
        r_wb         <= ~r_wb;
      end
      if (w_release) begin
        r_full[r_rb] <= 1'b0;
        r_rb         <= ~r_rb;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_mem <= '0;
    end else if (w_pix_fire) begin
      r_mem[r_wb][r_row][r_col] <= i_pix_data;
    end
  end

  for (genvar gi = 0; gi < KH; gi++) begin : g_rows
    logic [5:0] w_row;
    assign w_row     = {1'b0, i_addr} + 6'(gi);
    assign o_data[gi] = (w_row < c_IMG_H6) ? r_mem[r_rb][w_row[c_RW-1:0]] : '0;
  end
`else
  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t                            r_state;
  logic [IMG_H-1:0][IMG_W-1:0][DW-1:0] r_mem;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= S_FILL;
      o_pix_ready  <= 1'b1;
      o_post_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_pix_fire && w_last_pix) begin
            r_state      <= S_FULL;
            o_pix_ready  <= 1'b0;
            o_post_valid <= 1'b1;
          end
        end
        S_FULL: begin
          if (w_release) begin
            r_state      <= S_FILL;
            o_pix_ready  <= 1'b1;
            o_post_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_FILL;
          o_pix_ready  <= 1'b1;
          o_post_valid <= 1'b0;
        end
      endcase
    end
  end

  // o_pix_ready is low in FULL, so storage is frozen while it is read.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_mem <= '0;
    end else if (w_pix_fire) begin
      r_mem[r_row][r_col] <= i_pix_data;
    end
  end

  for (genvar gi = 0; gi < KH; gi++) begin : g_rows
    logic [5:0] w_row;
    assign w_row      = {1'b0, i_addr} + 6'(gi);
    assign o_data[gi] = (w_row < c_IMG_H6) ? r_mem[w_row[c_RW-1:0]] : '0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_img_row_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_img_row_buffer
//  Purpose  : Directed self-checking bench for img_row_buffer (28x28x8, KH=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_img_row_buffer;

  logic                    i_clk;
  logic                    i_rstn;
  logic                    i_pix_valid;
  logic                    o_pix_ready;
  logic [7:0]              i_pix_data;
  logic                    o_post_valid;
  logic                    i_post_ready;
  logic [4:0]              i_addr;
  logic [2:0][27:0][7:0]   o_data;

  int n_chk = 0;
  int n_err = 0;

  img_row_buffer #(.IMG_W(28), .IMG_H(28), .DW(8), .KH(3)) u_dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_pix_valid (i_pix_valid),
    .o_pix_ready (o_pix_ready),
    .i_pix_data  (i_pix_data),
    .o_post_valid(o_post_valid),
    .i_post_ready(i_post_ready),
    .i_addr      (i_addr),
    .o_data      (o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] d, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        i_pix_valid = 1'b0;
        tick();
      end
    end
    i_pix_valid = 1'b1;
    i_pix_data  = d;
    tick();
    i_pix_valid = 1'b0;
  endtask

  function automatic logic [7:0] pat(input int r, input int c);
    return 8'((r * 28 + c) & 8'hFF);
  endfunction

  // Counts o_data bytes that differ from the pattern (or a constant) over
  // every valid window address.
  task automatic scan(input bit use_pat, input logic [7:0] k, output int bad);
    bad = 0;
    for (int a = 0; a <= 25; a++) begin
      i_addr = 5'(a);
      #1;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 28; j++)
          if (o_data[i][j] !== (use_pat ? pat(a + i, j) : k)) bad++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    i_rstn = 1'b0; i_pix_valid = 1'b0; i_pix_data = '0;
    i_post_ready = 1'b0; i_addr = '0;
    repeat (2) tick();
    check("rst_pix_ready", o_pix_ready, 1);
    check("rst_post_valid", o_post_valid, 0);
    check("rst_data_a0", o_data[0][0], 0);
    i_addr = 5'd25; #1;
    check("rst_data_a25", o_data[2][27], 0);
    i_addr = 5'd0;
    i_rstn = 1'b1;

`ifdef IMG_BUF_PINGPONG_EN
    for (int k = 0; k < 784; k++) send_pix(pat(k / 28, k % 28), 1'b0);
    check("pp_a_valid", o_post_valid, 1);
    check("pp_a_ready", o_pix_ready, 1);
    for (int k = 0; k < 784; k++) send_pix(8'h5A, 1'b0);
    check("pp_b_stall", o_pix_ready, 0);
    i_pix_valid = 1'b1; i_pix_data = 8'hC3;
    repeat (5) tick();
    check("pp_third_stall", o_pix_ready, 0);
    i_pix_valid = 1'b0;
    i_addr = 5'd0; #1;
    check("pp_a_data", o_data[1][0], 28);
    i_addr = 5'd25; i_post_ready = 1'b1;
    tick();
    i_post_ready = 1'b0;
    check("pp_rel_ready", o_pix_ready, 1);
    check("pp_rel_valid", o_post_valid, 1);
    scan(1'b0, 8'h5A, bad);
    check("pp_b_frame", bad, 0);
`else
    // Load and read
    for (int k = 0; k < 783; k++) send_pix(pat(k / 28, k % 28), 1'b0);
    check("fill_not_valid", o_post_valid, 0);
    send_pix(pat(27, 27), 1'b0);
    check("full_valid", o_post_valid, 1);
    check("full_not_ready", o_pix_ready, 0);
    i_addr = 5'd0; #1;
    check("a0_r0c0", o_data[0][0], 0);
    check("a0_r1c0", o_data[1][0], 28);
    check("a0_r2c27", o_data[2][27], 83);
    i_addr = 5'd25; #1;
    check("a25_r0c0", o_data[0][0], 188);
    check("a25_r2c27", o_data[2][27], 15);
    i_addr = 5'd26; #1;
    check("a26_r1c0", o_data[1][0], 244);
    check("a26_r2c5", o_data[2][5], 0);
    i_addr = 5'd31; #1;
    check("a31_r0c0", o_data[0][0], 0);

    // Backpressure: upstream pushes 0xAA while the frame is held
    i_post_ready = 1'b0; i_pix_valid = 1'b1; i_pix_data = 8'hAA;
    repeat (10) tick();
    i_pix_valid = 1'b0;
    check("bp_valid", o_post_valid, 1);
    check("bp_ready", o_pix_ready, 0);
    scan(1'b1, 8'h00, bad);
    check("bp_frame", bad, 0);

    // Non-releasing reads, including out-of-range addresses
    i_post_ready = 1'b1;
    for (int a = 0; a <= 24; a++) begin
      i_addr = 5'(a);
      tick();
    end
    i_addr = 5'd26; tick();
    i_addr = 5'd31; tick();
    check("noreL_valid", o_post_valid, 1);
    i_addr = 5'd25; tick();
    i_post_ready = 1'b0;
    check("rel_valid", o_post_valid, 0);
    check("rel_ready", o_pix_ready, 1);

    // Refill with random upstream gaps
    for (int k = 0; k < 784; k++) send_pix(pat(k / 28, k % 28), 1'b1);
    check("gap_valid", o_post_valid, 1);
    scan(1'b1, 8'h00, bad);
    check("gap_frame", bad, 0);
    i_addr = 5'd25; i_post_ready = 1'b1; tick();
    i_post_ready = 1'b0;
    check("gap_rel_ready", o_pix_ready, 1);

    // Reset mid-fill discards the partial frame
    for (int k = 0; k < 300; k++) send_pix(8'h11, 1'b0);
    i_rstn = 1'b0; tick();
    i_addr = 5'd0; #1;
    check("mrst_ready", o_pix_ready, 1);
    check("mrst_data", o_data[0][0], 0);
    i_rstn = 1'b1;
    for (int k = 0; k < 783; k++) send_pix(8'h5A, 1'b0);
    check("mrst_not_valid", o_post_valid, 0);
    send_pix(8'h5A, 1'b0);
    check("mrst_valid", o_post_valid, 1);
    scan(1'b0, 8'h5A, bad);
    check("mrst_frame", bad, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
